axis_rr_arbiter: RTL and testbench

AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

---
 rtl/axis_rr_arbiter.sv | 118 +++++++++++
 tb/tb_axis_rr_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-level round-robin merge of N_IN AXI-Stream inputs
// onto a single output stream. A port owns the output from its first beat
// until its last-beat handshake; one idle cycle separates packets.
module axis_rr_arbiter #(
  parameter int N_IN   = 4,
  parameter int WORD_W = 8,
  parameter int BUS_W  = 32,
  parameter int CNT_W  = 16,
  localparam int WORDS_PER_BEAT = BUS_W / WORD_W
) (
  input  logic                                              clk,
  input  logic                                              rstn,
  input  logic [N_IN-1:0]                                   s_valid,
  output logic [N_IN-1:0]                                   s_ready,
  input  logic [N_IN-1:0][WORDS_PER_BEAT-1:0][WORD_W-1:0]   s_data,
  input  logic [N_IN-1:0][WORDS_PER_BEAT-1:0]               s_keep,
  input  logic [N_IN-1:0]                                   s_last,
  output logic                                              m_valid,
  input  logic                                              m_ready,
  output logic [WORDS_PER_BEAT-1:0][WORD_W-1:0]             m_data,
  output logic [WORDS_PER_BEAT-1:0]                         m_keep,
  output logic                                              m_last,
  output logic [N_IN-1:0]                                   grant,
  output logic [N_IN-1:0][CNT_W-1:0]                        pkt_cnt
);

  localparam int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel, sel_nxt;
  logic [SEL_W-1:0] last_grant, last_grant_nxt;
  logic [SEL_W-1:0] pick;
  logic             pick_found;
  logic [SEL_W:0]   cand;
  logic             done;

  // Round-robin search: first requester at or above last_grant+1, wrapping.
  // The sum never exceeds 2*N_IN-1, so a single conditional subtract is the modulo.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      cand = {1'b0, last_grant} + (SEL_W+1)'(i + 1);
      if (cand >= (SEL_W+1)'(N_IN)) begin
        cand = cand - (SEL_W+1)'(N_IN);
      end
      if (!pick_found && s_valid[cand[SEL_W-1:0]]) begin
        pick       = cand[SEL_W-1:0];
        pick_found = 1'b1;
      end
    end
  end

  // Next-state and output mux; outputs are all zero unless a port owns the bus.
  always_comb begin
    state_nxt      = state;
    sel_nxt        = sel;
    last_grant_nxt = last_grant;
    m_valid        = 1'b0;
    m_data         = '0;
    m_keep         = '0;
    m_last         = 1'b0;
    s_ready        = '0;
    grant          = '0;
    done           = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          sel_nxt   = pick;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        m_valid      = s_valid[sel];
        m_data       = s_data[sel];
        m_keep       = s_keep[sel];
        m_last       = s_last[sel];
        s_ready[sel] = m_ready;
        grant[sel]   = 1'b1;
        done         = s_valid[sel] & m_ready & s_last[sel];
        if (done) begin
          last_grant_nxt = sel;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, owner and round-robin pointer; reset gives port 0 first priority.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      sel        <= '0;
      last_grant <= SEL_W'(N_IN - 1);
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Per-port completed-packet counters, wrapping silently.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pkt_cnt <= '0;
    end else if (done) begin
      pkt_cnt[sel] <= pkt_cnt[sel] + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter: a cycle table from reset, directed
// multi-cycle sequences, and a packet source/sink scoreboard.
module tb_axis_rr_arbiter;

  localparam int N_IN   = 4;
  localparam int WORD_W = 8;
  localparam int BUS_W  = 32;
  localparam int CNT_W  = 4;
  localparam int WPB    = BUS_W / WORD_W;
  localparam int MAXPK  = 20;

  logic                                  clk = 1'b0;
  logic                                  rstn;
  logic [N_IN-1:0]                       s_valid, s_ready, s_last, grant;
  logic [N_IN-1:0][WPB-1:0][WORD_W-1:0]  s_data;
  logic [N_IN-1:0][WPB-1:0]              s_keep;
  logic                                  m_valid, m_ready, m_last;
  logic [WPB-1:0][WORD_W-1:0]            m_data;
  logic [WPB-1:0]                        m_keep;
  logic [N_IN-1:0][CNT_W-1:0]            pkt_cnt;

  int checks = 0;
  int errors = 0;

  axis_rr_arbiter #(
    .N_IN   (N_IN),
    .WORD_W (WORD_W),
    .BUS_W  (BUS_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_keep  (s_keep),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_keep  (m_keep),
    .m_last  (m_last),
    .grant   (grant),
    .pkt_cnt (pkt_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    logic [N_IN-1:0] sv;
    logic [N_IN-1:0] sl;
    logic            mr;
    logic [N_IN-1:0] e_grant;
    logic            e_valid;
    logic            e_last;
  } vec_t;

  localparam int NV = 17;
  vec_t vec [NV];

  int plen   [N_IN][MAXPK];
  int pwords [N_IN][MAXPK];
  int npk    [N_IN];
  int src_pkt[N_IN], src_beat[N_IN], snk_pkt[N_IN], snk_beat[N_IN];
  int log_port[$];
  int log_cyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BUS_W-1:0] tword(input int p);
    return 32'hC0DE0000 + 32'(p) * 32'h0101;
  endfunction

  function automatic logic [WPB-1:0] tkeep(input int p);
    return WPB'(p + 1);
  endfunction

  function automatic logic [BUS_W-1:0] beat_word(input int p, input int k, input int b);
    return {8'(p), 8'(k), 8'(b), 8'h5A};
  endfunction

  function automatic logic [WPB-1:0] beat_keep(input int p, input int k, input int b);
    int rem;
    if (b != plen[p][k] - 1) return '1;
    rem = pwords[p][k] % WPB;
    if (rem == 0) return '1;
    return WPB'((1 << rem) - 1);
  endfunction

  task automatic set_const_data();
    for (int p = 0; p < N_IN; p++) begin
      s_data[p] = tword(p);
      s_keep[p] = tkeep(p);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn    = 1'b0;
    s_valid = '0;
    s_last  = '0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic cyc(input logic [N_IN-1:0] sv, input logic [N_IN-1:0] sl, input logic mr);
    @(posedge clk); #1;
    s_valid = sv;
    s_last  = sl;
    m_ready = mr;
    #1;
  endtask

  task automatic clear_traffic();
    for (int p = 0; p < N_IN; p++) npk[p] = 0;
  endtask

  task automatic add_pkt(input int p, input int words);
    plen[p][npk[p]]   = (words + WPB - 1) / WPB;
    pwords[p][npk[p]] = words;
    npk[p]++;
  endtask

  // Sources send their packet lists back-to-back; the sink checks every beat.
  task automatic run_traffic(input int max_cycles, input int ready_pct, output int cycles);
    int  cur;
    int  p;
    bit  all_done;
    bit  exp_last;
    cur      = -1;
    cycles   = 0;
    all_done = 1'b0;
    for (int q = 0; q < N_IN; q++) begin
      src_pkt[q] = 0; src_beat[q] = 0; snk_pkt[q] = 0; snk_beat[q] = 0;
    end
    log_port.delete();
    log_cyc.delete();
    while (!all_done && cycles < max_cycles) begin
      @(posedge clk); #1;
      for (int q = 0; q < N_IN; q++) begin
        if (src_pkt[q] < npk[q]) begin
          s_valid[q] = 1'b1;
          s_last[q]  = (src_beat[q] == plen[q][src_pkt[q]] - 1);
          s_data[q]  = beat_word(q, src_pkt[q], src_beat[q]);
          s_keep[q]  = beat_keep(q, src_pkt[q], src_beat[q]);
        end else begin
          s_valid[q] = 1'b0;
          s_last[q]  = 1'b0;
        end
      end
      m_ready = ($urandom_range(99) < ready_pct);
      #1;
      cycles++;
      if (m_valid && m_ready) begin
        p = int'(m_data[WPB-1]);
        check("sink_port_range", p < N_IN, 1);
        if (p < N_IN) begin
          check("sink_grant", grant, N_IN'(1) << p);
          if (cur >= 0) check("sink_interleave", p, cur);
          check("sink_extra_beat", snk_pkt[p] < npk[p], 1);
          if (snk_pkt[p] < npk[p]) begin
            exp_last = (snk_beat[p] == plen[p][snk_pkt[p]] - 1);
            check("sink_data", m_data, beat_word(p, snk_pkt[p], snk_beat[p]));
            check("sink_keep", m_keep, beat_keep(p, snk_pkt[p], snk_beat[p]));
            check("sink_last", m_last, exp_last);
            log_port.push_back(p);
            log_cyc.push_back(cycles);
            if (exp_last) begin
              snk_pkt[p]++;
              snk_beat[p] = 0;
              cur = -1;
            end else begin
              snk_beat[p]++;
              cur = p;
            end
          end
        end
      end
      for (int q = 0; q < N_IN; q++) begin
        if (s_valid[q] && s_ready[q]) begin
          if (src_beat[q] == plen[q][src_pkt[q]] - 1) begin
            src_pkt[q]++;
            src_beat[q] = 0;
          end else begin
            src_beat[q]++;
          end
        end
      end
      all_done = 1'b1;
      for (int q = 0; q < N_IN; q++) if (snk_pkt[q] != npk[q]) all_done = 1'b0;
    end
    check("traffic_done", all_done, 1);
    @(posedge clk); #1;
    s_valid = '0;
    s_last  = '0;
    m_ready = 1'b1;
    #1;
  endtask

  initial begin
    int              cycles;
    int              idx;
    logic [BUS_W-1:0] e_data;
    logic [WPB-1:0]   e_keep;

    vec[0]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0};
    vec[1]  = '{4'b1010, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0};
    vec[2]  = '{4'b1011, 4'b0000, 1'b1, 4'b0010, 1'b1, 1'b0};
    vec[3]  = '{4'b1001, 4'b0000, 1'b1, 4'b0010, 1'b0, 1'b0};
    vec[4]  = '{4'b1011, 4'b0000, 1'b0, 4'b0010, 1'b1, 1'b0};
    vec[5]  = '{4'b1011, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1};
    vec[6]  = '{4'b1011, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b1};
    vec[7]  = '{4'b1001, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0};
    vec[8]  = '{4'b1001, 4'b1001, 1'b1, 4'b1000, 1'b1, 1'b1};
    vec[9]  = '{4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0};
    vec[10] = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0};
    vec[11] = '{4'b1111, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1};
    vec[12] = '{4'b1110, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0};
    vec[13] = '{4'b0110, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b1};
    vec[14] = '{4'b0100, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0};
    vec[15] = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1};
    vec[16] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0};

    // Outputs held at zero during reset even with every port requesting.
    rstn    = 1'b1;
    s_valid = '1;
    s_last  = '1;
    m_ready = 1'b1;
    set_const_data();
    #2 rstn = 1'b0;
    #10;
    check("rst_m_valid", m_valid, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_grant", grant, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_keep", m_keep, 0);
    check("rst_m_last", m_last, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    s_valid = '0;
    s_last  = '0;
    @(negedge clk);
    rstn = 1'b1;

    // Cycle-by-cycle table starting from the reset state.
    for (int k = 0; k < NV; k++) begin
      @(posedge clk); #1;
      s_valid = vec[k].sv;
      s_last  = vec[k].sl;
      m_ready = vec[k].mr;
      #1;
      idx = -1;
      for (int p = 0; p < N_IN; p++) if (vec[k].e_grant[p]) idx = p;
      e_data = (idx >= 0) ? tword(idx) : '0;
      e_keep = (idx >= 0) ? tkeep(idx) : '0;
      check($sformatf("vec%0d_grant", k), grant, vec[k].e_grant);
      check($sformatf("vec%0d_s_ready", k), s_ready, vec[k].mr ? vec[k].e_grant : 4'b0000);
      check($sformatf("vec%0d_m_valid", k), m_valid, vec[k].e_valid);
      check($sformatf("vec%0d_m_last", k), m_last, vec[k].e_last);
      check($sformatf("vec%0d_m_data", k), m_data, e_data);
      check($sformatf("vec%0d_m_keep", k), m_keep, e_keep);
    end
    check("vec_pkt_cnt", pkt_cnt, 16'h1121);

    // Four 3-beat packets offered together: strict order 0,1,2,3 with bubbles.
    do_reset();
    clear_traffic();
    for (int p = 0; p < N_IN; p++) add_pkt(p, 3 * WPB);
    run_traffic(100, 100, cycles);
    check("rr4_cycles", cycles, 16);
    check("rr4_beats", log_port.size(), 12);
    for (int i = 0; i < log_port.size() && i < 12; i++) begin
      check($sformatf("rr4_port%0d", i), log_port[i], i / 3);
      check($sformatf("rr4_cyc%0d", i), log_cyc[i], 2 + (i / 3) * 4 + (i % 3));
    end
    check("rr4_pkt_cnt", pkt_cnt, 16'h1111);

    // Seventeen single-beat packets on port 0 wrap the 4-bit counter to 1.
    do_reset();
    clear_traffic();
    for (int i = 0; i < 17; i++) add_pkt(0, 1);
    run_traffic(200, 100, cycles);
    check("wrap_cycles", cycles, 34);
    check("wrap_pkt_cnt0", pkt_cnt[0], 1);

    // Port 2 keeps ownership while port 0 requests mid-packet.
    do_reset();
    set_const_data();
    cyc(4'b0100, 4'b0000, 1'b1);
    check("hold_idle_grant", grant, 4'b0000);
    cyc(4'b0100, 4'b0000, 1'b1);
    check("hold_b0_grant", grant, 4'b0100);
    cyc(4'b0100, 4'b0000, 1'b1);
    check("hold_b1_grant", grant, 4'b0100);
    for (int b = 2; b < 4; b++) begin
      cyc(4'b0101, 4'b0000, 1'b1);
      check($sformatf("hold_b%0d_grant", b), grant, 4'b0100);
      check($sformatf("hold_b%0d_s_ready", b), s_ready, 4'b0100);
    end
    cyc(4'b0101, 4'b0101, 1'b1);
    check("hold_b4_s_ready", s_ready, 4'b0100);
    check("hold_b4_m_last", m_last, 1);
    cyc(4'b0001, 4'b0001, 1'b1);
    check("hold_bubble_grant", grant, 4'b0000);
    cyc(4'b0001, 4'b0001, 1'b1);
    check("hold_next_grant", grant, 4'b0001);
    check("hold_next_s_ready", s_ready, 4'b0001);
    cyc(4'b0000, 4'b0000, 1'b1);
    check("hold_pkt_cnt", pkt_cnt, 16'h0101);

    // Two single-beat packets on port 1, one bubble between them.
    cyc(4'b0010, 4'b0010, 1'b1);
    check("single_idle0", grant, 4'b0000);
    cyc(4'b0010, 4'b0010, 1'b1);
    check("single_p0_grant", grant, 4'b0010);
    check("single_p0_last", m_valid & m_last, 1);
    cyc(4'b0010, 4'b0010, 1'b1);
    check("single_bubble", grant, 4'b0000);
    cyc(4'b0010, 4'b0010, 1'b1);
    check("single_p1_grant", grant, 4'b0010);
    cyc(4'b0000, 4'b0000, 1'b1);
    check("single_pkt_cnt", pkt_cnt, 16'h0121);

    // Reset asserted during the third beat of a port 1 packet.
    cyc(4'b0010, 4'b0000, 1'b1);
    cyc(4'b0010, 4'b0000, 1'b1);
    cyc(4'b0010, 4'b0000, 1'b1);
    cyc(4'b0010, 4'b0000, 1'b1);
    check("mrst_pre_grant", grant, 4'b0010);
    #1 rstn = 1'b0;
    #1;
    check("mrst_grant", grant, 4'b0000);
    check("mrst_m_valid", m_valid, 0);
    check("mrst_s_ready", s_ready, 4'b0000);
    check("mrst_m_data", m_data, 0);
    check("mrst_pkt_cnt", pkt_cnt, 0);
    s_valid = 4'b0011;
    s_last  = 4'b0000;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("mrst_release_idle", grant, 4'b0000);
    @(posedge clk); #1;
    check("mrst_first_grant", grant, 4'b0001);
    cyc(4'b0000, 4'b0000, 1'b1);

    // Random packet mix with a mostly-stalled sink.
    do_reset();
    clear_traffic();
    for (int i = 0; i < 20; i++) add_pkt($urandom_range(N_IN - 1), $urandom_range(100, 1));
    run_traffic(30000, 10, cycles);
    for (int p = 0; p < N_IN; p++) begin
      check($sformatf("rand_pkt_cnt%0d", p), pkt_cnt[p], CNT_W'(npk[p]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
